// File: rtl/i2c_packet_fifo_pkg.sv
// Shared FIFO sizing and pointer compare helpers for the I2C packet buffering stage.
// Pointers carry one extra wrap bit above the address bits.
package i2c_packet_fifo_pkg;

    localparam int FIFO_ADDR_W = 6;

    function automatic logic ptr_empty(input int unsigned wp, input int unsigned rp);
        return wp == rp;
    endfunction

    // Full when only the wrap bit differs.
    function automatic logic ptr_full(input int unsigned wp, input int unsigned rp, input int addr_w);
        return (wp ^ rp) == (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data and a one-cycle
// pulse when a push is refused because the FIFO is full.
module i2c_sync_fifo
    import i2c_packet_fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_en,
    input  logic [7:0] push_dat,
    output logic       full,
    output logic       drop,
    input  logic       pop_en,
    output logic [7:0] pop_dat,
    output logic       empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            push;
    logic            pop;

    // Full is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign full    = ptr_full(32'(wr_ptr), 32'(rd_ptr), ADDR_W);
    assign empty   = ptr_empty(32'(wr_ptr), 32'(rd_ptr));
    assign push    = push_en && !full;
    assign pop     = pop_en && !empty;
    assign pop_dat = mem[rd_ptr[ADDR_W-1:0]];

    // NOTE: the storage array has no reset; the pointers alone define valid contents.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= push_dat;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= push_en && full;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/i2c_packet_fifo.sv
// Buffers host request bytes toward the I2C controller and controller response bytes
// toward the host; responses become visible only once the controller commits a packet.
module i2c_packet_fifo
    import i2c_packet_fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             host_wr_i,
    input  logic [7:0]       host_dat_i,
    output logic             host_full_o,
    output logic             req_drop_o,
    output logic [7:0]       ctl_dat_o,
    output logic             ctl_empty_o,
    input  logic             ctl_rd_i,
    input  logic [7:0]       ctl_dat_i,
    input  logic             ctl_wr_i,
    input  logic             ctl_packet_i,
    output logic             ctl_full_o,
    output logic [7:0]       host_dat_o,
    output logic             host_eop_o,
    output logic             host_empty_o,
    input  logic             host_rd_i,
    output logic [CNT_W-1:0] host_pkt_count_o,
    output logic             pkt_err_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = DEPTH;

    i2c_sync_fifo #(.ADDR_W(ADDR_W)) u_req_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .push_en  (host_wr_i),
        .push_dat (host_dat_i),
        .full     (host_full_o),
        .drop     (req_drop_o),
        .pop_en   (ctl_rd_i),
        .pop_dat  (ctl_dat_o),
        .empty    (ctl_empty_o)
    );

    logic [7:0]       resp_mem [DEPTH];
    logic [DEPTH-1:0] eop;
    logic [ADDR_W:0]  wr_ptr, cm_ptr, rd_ptr, wr_next, last_ptr;
    logic             ovf, ovf_now, wr_take, wr_drop, rd_take, eop_pop;
    logic             do_commit, do_discard;
    logic [CNT_W-1:0] pkt_count;

    // Uncommitted bytes occupy space, so full compares the write pointer with the read pointer.
    assign ctl_full_o       = ptr_full(32'(wr_ptr), 32'(rd_ptr), ADDR_W);
    assign host_empty_o     = ptr_empty(32'(rd_ptr), 32'(cm_ptr));
    assign wr_take          = ctl_wr_i && !ctl_full_o;
    assign wr_drop          = ctl_wr_i && ctl_full_o;
    assign ovf_now          = ovf || wr_drop;
    assign wr_next          = wr_take ? wr_ptr + PTR_ONE : wr_ptr;
    assign last_ptr         = wr_next - PTR_ONE;
    assign rd_take          = host_rd_i && !host_empty_o;
    assign eop_pop          = rd_take && eop[rd_ptr[ADDR_W-1:0]];
    assign host_dat_o       = resp_mem[rd_ptr[ADDR_W-1:0]];
    assign host_eop_o       = eop[rd_ptr[ADDR_W-1:0]] && !host_empty_o;
    assign host_pkt_count_o = pkt_count;

    // A same-cycle write is folded in before the commit decision is made.
    always_comb begin
        // NOTE: both outputs get a default first so no latch is inferred on any path.
        do_commit  = 1'b0;
        do_discard = 1'b0;
        if (ctl_packet_i && wr_next != cm_ptr) begin
            if (ovf_now) do_discard = 1'b1;
            else         do_commit  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_take) resp_mem[wr_ptr[ADDR_W-1:0]] <= ctl_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            rd_ptr    <= '0;
            eop       <= '0;
            ovf       <= 1'b0;
            pkt_count <= '0;
            pkt_err_o <= 1'b0;
        end else begin
            pkt_err_o <= do_discard;
            if (wr_take) eop[wr_ptr[ADDR_W-1:0]] <= 1'b0;
            if (rd_take) rd_ptr <= rd_ptr + PTR_ONE;
            if (do_discard) wr_ptr <= cm_ptr;
            else            wr_ptr <= wr_next;
            // Placed after the write-side clear so a write+commit byte ends up tagged.
            if (do_commit) begin
                eop[last_ptr[ADDR_W-1:0]] <= 1'b1;
                cm_ptr                    <= wr_next;
            end
            if (ctl_packet_i) ovf <= 1'b0;
            else if (wr_drop) ovf <= 1'b1;
            if (do_commit && !eop_pop)      pkt_count <= pkt_count + CNT_ONE;
            else if (!do_commit && eop_pop) pkt_count <= pkt_count - CNT_ONE;
        end
    end

    count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_n_i) pkt_count <= CNT_MAX);

endmodule

// File: tb/tb_i2c_packet_fifo.sv
// Bench for i2c_packet_fifo: directed scenarios plus a randomized run against a queue-based model.
module tb_i2c_packet_fifo;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       host_wr_i = 1'b0, ctl_rd_i = 1'b0, ctl_wr_i = 1'b0, ctl_packet_i = 1'b0, host_rd_i = 1'b0;
    logic [7:0] host_dat_i = '0, ctl_dat_i = '0;
    logic       host_full_o, req_drop_o, ctl_empty_o, ctl_full_o, host_eop_o, host_empty_o, pkt_err_o;
    logic [7:0] ctl_dat_o, host_dat_o;
    logic [6:0] host_pkt_count_o;

    int vecs = 0;
    int errs = 0;

    // Reference model state: plain queues of bytes.
    logic [7:0] req_q[$];
    logic [7:0] pend_q[$];
    logic [8:0] cm_q[$];
    bit         m_ovf, m_drop, m_err;
    int         m_cnt;

    i2c_packet_fifo dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .host_wr_i(host_wr_i), .host_dat_i(host_dat_i), .host_full_o(host_full_o), .req_drop_o(req_drop_o),
        .ctl_dat_o(ctl_dat_o), .ctl_empty_o(ctl_empty_o), .ctl_rd_i(ctl_rd_i),
        .ctl_dat_i(ctl_dat_i), .ctl_wr_i(ctl_wr_i), .ctl_packet_i(ctl_packet_i), .ctl_full_o(ctl_full_o),
        .host_dat_o(host_dat_o), .host_eop_o(host_eop_o), .host_empty_o(host_empty_o), .host_rd_i(host_rd_i),
        .host_pkt_count_o(host_pkt_count_o), .pkt_err_o(pkt_err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic model_clear();
        req_q.delete(); pend_q.delete(); cm_q.delete();
        m_ovf = 0; m_drop = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic hw, input logic [7:0] hd, input logic cr,
                              input logic cw, input logic [7:0] cd, input logic cp, input logic hr);
        bit rfull = (req_q.size() == 64);
        bit sfull = (cm_q.size() + pend_q.size() >= 64);
        bit ovf_now = m_ovf;
        m_drop = hw && rfull;
        if (cr && req_q.size() != 0) void'(req_q.pop_front());
        if (hw && !rfull) req_q.push_back(hd);
        if (hr && cm_q.size() != 0) begin
            logic [8:0] b = cm_q.pop_front();
            if (b[8]) m_cnt--;
        end
        if (cw) begin
            if (!sfull) pend_q.push_back(cd);
            else        ovf_now = 1;
        end
        m_err = 0;
        if (cp) begin
            if (pend_q.size() == 0) ovf_now = 0;
            else if (ovf_now) begin
                pend_q.delete(); ovf_now = 0; m_err = 1;
            end else begin
                for (int i = 0; i < pend_q.size(); i++) begin
                    logic last = (i == pend_q.size() - 1);
                    cm_q.push_back({last, pend_q[i]});
                end
                pend_q.delete();
                m_cnt++;
            end
        end
        m_ovf = ovf_now;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic hw, input logic [7:0] hd, input logic cr,
                        input logic cw, input logic [7:0] cd, input logic cp, input logic hr);
        host_wr_i = hw; host_dat_i = hd; ctl_rd_i = cr;
        ctl_wr_i = cw; ctl_dat_i = cd; ctl_packet_i = cp; host_rd_i = hr;
        model_step(hw, hd, cr, cw, cd, cp, hr);
        @(posedge clk_i); #1;
        host_wr_i = 0; ctl_rd_i = 0; ctl_wr_i = 0; ctl_packet_i = 0; host_rd_i = 0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        host_wr_i = 0; ctl_rd_i = 0; ctl_wr_i = 0; ctl_packet_i = 0; host_rd_i = 0;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; model_clear();
        #3;
        vecs++; if (host_full_o !== 1'b0) begin errs++; $display("FAIL reset_host_full: got %b want 0", host_full_o); end
        vecs++; if (ctl_empty_o !== 1'b1) begin errs++; $display("FAIL reset_ctl_empty: got %b want 1", ctl_empty_o); end
        vecs++; if (ctl_full_o !== 1'b0) begin errs++; $display("FAIL reset_ctl_full: got %b want 0", ctl_full_o); end
        vecs++; if (host_empty_o !== 1'b1) begin errs++; $display("FAIL reset_host_empty: got %b want 1", host_empty_o); end
        vecs++; if (req_drop_o !== 1'b0 || pkt_err_o !== 1'b0) begin errs++; $display("FAIL reset_pulses: got %b%b want 00", req_drop_o, pkt_err_o); end
        vecs++; if (host_pkt_count_o !== 7'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", host_pkt_count_o); end
        do_reset();
    endtask

    task automatic test_req_basic();
        step(1, 8'hA5, 0, 0, 0, 0, 0);
        vecs++; if (ctl_empty_o !== 1'b0) begin errs++; $display("FAIL req_not_empty: got %b want 0", ctl_empty_o); end
        vecs++; if (ctl_dat_o !== 8'hA5) begin errs++; $display("FAIL req_head_a5: got %h want a5", ctl_dat_o); end
        step(1, 8'h3C, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        vecs++; if (ctl_dat_o !== 8'h3C) begin errs++; $display("FAIL req_head_3c: got %h want 3c", ctl_dat_o); end
        step(0, 0, 1, 0, 0, 0, 0);
        vecs++; if (ctl_empty_o !== 1'b1) begin errs++; $display("FAIL req_drained: got %b want 1", ctl_empty_o); end
    endtask

    task automatic test_req_full();
        for (int i = 0; i < 64; i++) step(1, 8'(i), 0, 0, 0, 0, 0);
        vecs++; if (host_full_o !== 1'b1) begin errs++; $display("FAIL req_full_64: got %b want 1", host_full_o); end
        vecs++; if (req_drop_o !== 1'b0) begin errs++; $display("FAIL req_no_drop_64: got %b want 0", req_drop_o); end
        step(1, 8'hEE, 0, 0, 0, 0, 0);
        vecs++; if (req_drop_o !== 1'b1) begin errs++; $display("FAIL req_drop_65: got %b want 1", req_drop_o); end
        for (int i = 0; i < 64; i++) begin
            vecs++; if (ctl_dat_o !== 8'(i)) begin errs++; $display("FAIL req_drain[%0d]: got %h want %h", i, ctl_dat_o, 8'(i)); end
            step(0, 0, 1, 0, 0, 0, 0);
            if (i == 0) begin
                vecs++; if (req_drop_o !== 1'b0) begin errs++; $display("FAIL req_drop_one_cycle: got %b want 0", req_drop_o); end
            end
        end
        vecs++; if (ctl_empty_o !== 1'b1) begin errs++; $display("FAIL req_empty_after_drain: got %b want 1", ctl_empty_o); end
    endtask

    task automatic test_resp_commit();
        logic [7:0] want_d[3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, want_d[i], 0, 0);
            vecs++; if (host_empty_o !== 1'b1) begin errs++; $display("FAIL resp_uncommitted_hidden[%0d]: got %b want 1", i, host_empty_o); end
        end
        step(0, 0, 0, 0, 0, 1, 0);
        vecs++; if (host_empty_o !== 1'b0) begin errs++; $display("FAIL resp_commit_visible: got %b want 0", host_empty_o); end
        vecs++; if (host_pkt_count_o !== 7'd1) begin errs++; $display("FAIL resp_commit_count: got %0d want 1", host_pkt_count_o); end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (host_dat_o !== want_d[i] || host_eop_o !== (i == 2)) begin
                errs++; $display("FAIL resp_read[%0d]: got %h/eop%b want %h/eop%b", i, host_dat_o, host_eop_o, want_d[i], i == 2);
            end
            step(0, 0, 0, 0, 0, 0, 1);
        end
        vecs++; if (host_pkt_count_o !== 7'd0) begin errs++; $display("FAIL resp_count_after_read: got %0d want 0", host_pkt_count_o); end
    endtask

    task automatic test_same_cycle_commit();
        step(0, 0, 0, 1, 8'h44, 1, 0);
        vecs++; if (host_dat_o !== 8'h44 || host_eop_o !== 1'b1) begin errs++; $display("FAIL wr_commit_byte: got %h/eop%b want 44/eop1", host_dat_o, host_eop_o); end
        vecs++; if (host_pkt_count_o !== 7'd1) begin errs++; $display("FAIL wr_commit_count: got %0d want 1", host_pkt_count_o); end
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 70; i++) begin
            step(0, 0, 0, 1, 8'(i), 0, 0);
            if (i == 62) begin
                vecs++; if (ctl_full_o !== 1'b0) begin errs++; $display("FAIL ovf_not_full_63: got %b want 0", ctl_full_o); end
            end
            if (i == 63) begin
                vecs++; if (ctl_full_o !== 1'b1) begin errs++; $display("FAIL ovf_full_64: got %b want 1", ctl_full_o); end
            end
        end
        step(0, 0, 0, 0, 0, 1, 0);
        vecs++; if (pkt_err_o !== 1'b1) begin errs++; $display("FAIL ovf_pkt_err: got %b want 1", pkt_err_o); end
        vecs++; if (host_empty_o !== 1'b1 || host_pkt_count_o !== 7'd0) begin errs++; $display("FAIL ovf_discarded: got empty%b cnt%0d want empty1 cnt0", host_empty_o, host_pkt_count_o); end
        vecs++; if (ctl_full_o !== 1'b0) begin errs++; $display("FAIL ovf_rewound: got %b want 0", ctl_full_o); end
        step(0, 0, 0, 1, 8'h5A, 0, 0);
        vecs++; if (pkt_err_o !== 1'b0) begin errs++; $display("FAIL ovf_err_one_cycle: got %b want 0", pkt_err_o); end
        step(0, 0, 0, 1, 8'h6B, 1, 0);
        vecs++; if (host_pkt_count_o !== 7'd1 || host_dat_o !== 8'h5A || host_eop_o !== 1'b0) begin
            errs++; $display("FAIL ovf_next_packet: got cnt%0d %h/eop%b want cnt1 5a/eop0", host_pkt_count_o, host_dat_o, host_eop_o);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        vecs++; if (host_dat_o !== 8'h6B || host_eop_o !== 1'b1) begin errs++; $display("FAIL ovf_next_last: got %h/eop%b want 6b/eop1", host_dat_o, host_eop_o); end
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        step(0, 0, 0, 1, 8'hAA, 0, 0);
        step(0, 0, 0, 1, 8'hBB, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 8'hCC, 1, 1);
        vecs++; if (host_pkt_count_o !== 7'd1) begin errs++; $display("FAIL b2b_count: got %0d want 1", host_pkt_count_o); end
        vecs++; if (host_dat_o !== 8'hCC || host_eop_o !== 1'b1) begin errs++; $display("FAIL b2b_head: got %h/eop%b want cc/eop1", host_dat_o, host_eop_o); end
        step(1, 8'h77, 0, 1, 8'hDD, 0, 0);
        rst_n_i = 1'b0;
        #2;
        vecs++; if (host_empty_o !== 1'b1 || host_pkt_count_o !== 7'd0) begin errs++; $display("FAIL async_rst_resp: got empty%b cnt%0d want empty1 cnt0", host_empty_o, host_pkt_count_o); end
        vecs++; if (ctl_empty_o !== 1'b1 || ctl_full_o !== 1'b0 || host_full_o !== 1'b0) begin
            errs++; $display("FAIL async_rst_flags: got ce%b cf%b hf%b want 1 0 0", ctl_empty_o, ctl_full_o, host_full_o);
        end
        do_reset();
        step(0, 0, 0, 0, 0, 1, 0);
        vecs++; if (host_empty_o !== 1'b1 || pkt_err_o !== 1'b0) begin errs++; $display("FAIL rst_dropped_uncommitted: got empty%b err%b want 1 0", host_empty_o, pkt_err_o); end
    endtask

    task automatic test_random();
        int unsigned p_hw[4] = '{70, 20, 50, 90};
        int unsigned p_cr[4] = '{20, 80, 50, 10};
        int unsigned p_cw[4] = '{70, 30, 50, 90};
        int unsigned p_cp[4] = '{8, 20, 12, 3};
        int unsigned p_hr[4] = '{20, 80, 45, 10};
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            int k = ph % 4;
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(99) < p_hw[k], 8'($urandom), $urandom_range(99) < p_cr[k],
                     $urandom_range(99) < p_cw[k], 8'($urandom), $urandom_range(99) < p_cp[k],
                     $urandom_range(99) < p_hr[k]);
                vecs++; if (ctl_empty_o !== (req_q.size() == 0) || host_full_o !== (req_q.size() == 64) || req_drop_o !== m_drop) begin
                    errs++; $display("FAIL rnd_req_flags @%0t: got e%b f%b d%b want e%b f%b d%b", $time, ctl_empty_o, host_full_o, req_drop_o,
                                     req_q.size() == 0, req_q.size() == 64, m_drop);
                end
                vecs++; if (req_q.size() != 0 && ctl_dat_o !== req_q[0]) begin errs++; $display("FAIL rnd_req_data @%0t: got %h want %h", $time, ctl_dat_o, req_q[0]); end
                vecs++; if (ctl_full_o !== (cm_q.size() + pend_q.size() >= 64) || host_empty_o !== (cm_q.size() == 0) || pkt_err_o !== m_err) begin
                    errs++; $display("FAIL rnd_resp_flags @%0t: got f%b e%b err%b want f%b e%b err%b", $time, ctl_full_o, host_empty_o, pkt_err_o,
                                     cm_q.size() + pend_q.size() >= 64, cm_q.size() == 0, m_err);
                end
                vecs++; if (host_pkt_count_o !== 7'(m_cnt)) begin errs++; $display("FAIL rnd_count @%0t: got %0d want %0d", $time, host_pkt_count_o, m_cnt); end
                vecs++; if (cm_q.size() != 0 && (host_dat_o !== cm_q[0][7:0] || host_eop_o !== cm_q[0][8])) begin
                    errs++; $display("FAIL rnd_resp_head @%0t: got %h/eop%b want %h/eop%b", $time, host_dat_o, host_eop_o, cm_q[0][7:0], cm_q[0][8]);
                end
                vecs++; if (cm_q.size() == 0 && host_eop_o !== 1'b0) begin errs++; $display("FAIL rnd_eop_empty @%0t: got %b want 0", $time, host_eop_o); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_req_basic();
        test_req_full();
        test_resp_commit();
        test_same_cycle_commit();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
